beamformer_sequencer: RTL and testbench
=======================================

# beamformer_sequencer

Control FSM that drives the filter/beamformer datapath through one complete acquisition frame. It counts filtered samples into the filter output RAM, then replays each RAM word as three 32-bit channel slices into the delay beamformer. After a drain interval it reads the summed beam RAM out to a downstream consumer under a ready/valid handshake. It sits directly above the beamformer datapath and generates every address, enable, slice-select and index input that datapath needs.

## Interface
Parameters:
- NUM_SAMPLES, 2048: filter RAM words captured and processed per frame; must be at least 1 and at most 2^11.
- OUT_LEN, 1024: beam RAM words read out per frame; must be at least 1 and at most 2^10.
- DRAIN_CYCLES, 8: cycles to hold startbeamformer after the last slice so the beamformer pipeline empties; must be at least 1.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame request; honoured only in IDLE.
- filt_valid  in  1  filter output valid; identical to the datapath's RAM write enable.
- rd_ready  in  1  downstream consumer can accept a beam word this cycle.
- readin_address  out  11  filter RAM address, used for both the write and the read side.
- output_read_en  out  1  filter RAM read enable.
- startbeamformer  out  1  beamformer run enable.
- slice_state  out  2  0 = idle/delay, 1/2/3 = bits [31:0]/[63:32]/[95:64].
- sample_index  out  16  current processed sample; the address zero-extended.
- sumout_address  out  10  beam RAM read address.
- sumouten  out  1  beam RAM read enable.
- out_valid  out  1  beam RAM q holds a word that the consumer has not yet taken.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle frame-complete pulse.

## Operation
- States are IDLE, CAPTURE, P_ADDR, P_SLICE, DRAIN, READOUT and DONE. All outputs are registered except sumouten, which is combinational (state == READOUT && rd_ready).
- IDLE:
  - Every output is 0.
  - start=1 -> CAPTURE, with readin_address=0.
  - filt_valid is ignored.
- CAPTURE:
  - Each filt_valid=1 cycle increments readin_address. output_read_en stays 0.
  - On the NUM_SAMPLES-th filt_valid -> P_ADDR, with readin_address=0.
  - filt_valid arriving after the transition is ignored; the datapath writes it harmlessly at address 0, which is then re-read. This is a documented limitation.
- P_ADDR (1 cycle):
  - output_read_en=1, startbeamformer=1, slice_state=0, sample_index=readin_address.
  - Next state is P_SLICE with slice_state=1.
- P_SLICE (3 cycles per word):
  - slice_state steps 1 -> 2 -> 3. Address, output_read_en and startbeamformer are held.
  - After slice 3: if readin_address == NUM_SAMPLES-1 -> DRAIN, otherwise readin_address+1 -> P_ADDR.
- DRAIN:
  - startbeamformer=1, output_read_en=0, slice_state=0.
  - A counter runs from DRAIN_CYCLES-1 down to 0; at 0 -> READOUT with sumout_address=0.
- READOUT:
  - startbeamformer=0.
  - Each cycle with sumouten=1 the RAM read is issued at sumout_address and sumout_address then increments.
  - out_valid(t+1) = sumouten(t). The consumer samples q while out_valid=1; rd_ready=0 only stalls issue.
  - Issue at address OUT_LEN-1 -> DONE.
- DONE (1 cycle): done=1, out_valid=1 for the last word, busy=1. Next state is IDLE.
- start is ignored in every state except IDLE. Counters never wrap within a frame because the parameter bounds guarantee it.
- Asserting rst low at any point, mid-frame included, immediately forces IDLE with every output 0 and all counters 0. Captured RAM content is abandoned.

## Timing
- Start to first P_ADDR: 1 + (cycles until the NUM_SAMPLES-th filt_valid).
- Processing: exactly 4*NUM_SAMPLES cycles, followed by DRAIN_CYCLES cycles.
- Readout: OUT_LEN cycles plus one per rd_ready=0 cycle. The first out_valid comes 1 cycle after the first sumouten.
- The datapath latches slices on the falling edge. slice_state is stable for the full cycle after the rising edge, and filter RAM q is valid because the address was presented in P_ADDR one cycle earlier.
- done rises exactly 1 cycle after the final sumouten.

## Test plan
- Reset: hold rst=0 while start=1 and filt_valid=1 -> all outputs 0, busy=0. Release rst -> IDLE persists until the next start.
- Nominal frame (NUM_SAMPLES=4, OUT_LEN=4, DRAIN_CYCLES=2), 4 consecutive filt_valid, rd_ready=1:
  - readin_address during capture: 0, 1, 2, 3.
  - Processing: 16 cycles with slice pattern 0, 1, 2, 3 repeating and sample_index 0..3.
  - Then 2 drain cycles, then sumout_address 0..3.
  - out_valid on 4 cycles; done pulses once, 1 cycle after the last sumouten.
- Gapped capture: filt_valid on every 3rd cycle -> readin_address advances only on valid cycles, and the P_ADDR entry comes 1 cycle after the 4th valid.
- Readout backpressure: rd_ready toggling 1,0,0,1,1,0,1 -> sumout_address advances only on ready cycles, out_valid mirrors sumouten delayed by 1, and no address is skipped or repeated.
- Ignored start: pulse start during CAPTURE, P_SLICE and READOUT -> no state change; the frame completes with identical counts.
- Abort by reset: assert rst low during P_SLICE at address 2, slice 2 -> the next sampled state is IDLE with outputs 0. A following start runs a clean full frame.

Source files
------------

// File: rtl/beamformer_sequencer.sv
// Frame sequencer for the filter/beamformer datapath: capture, per-word slice
// replay, pipeline drain, then handshaked readout of the beam RAM.
module beamformer_sequencer #(
    parameter int NUM_SAMPLES  = 2048,
    parameter int OUT_LEN      = 1024,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        filt_valid,
    input  logic        rd_ready,
    output logic [10:0] readin_address,
    output logic        output_read_en,
    output logic        startbeamformer,
    output logic [1:0]  slice_state,
    output logic [15:0] sample_index,
    output logic [9:0]  sumout_address,
    output logic        sumouten,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);

    localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [10:0]     LAST_ADDR  = 11'(NUM_SAMPLES - 1);
    localparam logic [9:0]      LAST_SUM   = 10'(OUT_LEN - 1);
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CAPTURE, P_ADDR, P_SLICE, DRAIN, READOUT, DONE
    } state_t;

    state_t        state, state_n;
    logic [10:0]   addr_n;
    logic          ren_n, sb_n, ov_n, busy_n, done_n;
    logic [1:0]    slice_n;
    logic [9:0]    sum_n;
    logic [DW-1:0] drain_cnt, drain_n;

    assign sumouten = (state == READOUT) && rd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            readin_address  <= '0;
            output_read_en  <= 1'b0;
            startbeamformer <= 1'b0;
            slice_state     <= '0;
            sample_index    <= '0;
            sumout_address  <= '0;
            out_valid       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            drain_cnt       <= '0;
        end else begin
            state           <= state_n;
            readin_address  <= addr_n;
            output_read_en  <= ren_n;
            startbeamformer <= sb_n;
            slice_state     <= slice_n;
            sample_index    <= {5'b0, addr_n};
            sumout_address  <= sum_n;
            out_valid       <= ov_n;
            busy            <= busy_n;
            done            <= done_n;
            drain_cnt       <= drain_n;
        end
    end

    // Outputs are registered: next-state logic computes the value each output
    // must hold while the FSM sits in state_n.
    always_comb begin
        state_n = state;
        addr_n  = readin_address;
        ren_n   = output_read_en;
        sb_n    = startbeamformer;
        slice_n = slice_state;
        sum_n   = sumout_address;
        drain_n = drain_cnt;
        ov_n    = sumouten;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                addr_n  = '0;
                ren_n   = 1'b0;
                sb_n    = 1'b0;
                slice_n = '0;
                sum_n   = '0;
                drain_n = '0;
                if (start) state_n = CAPTURE;
            end
            CAPTURE: begin
                if (filt_valid) begin
                    if (readin_address == LAST_ADDR) begin
                        state_n = P_ADDR;
                        addr_n  = '0;
                        ren_n   = 1'b1;
                        sb_n    = 1'b1;
                        slice_n = '0;
                    end else begin
                        addr_n = readin_address + 11'd1;
                    end
                end
            end
            P_ADDR: begin
                state_n = P_SLICE;
                slice_n = 2'd1;
            end
            P_SLICE: begin
                if (slice_state == 2'd3) begin
                    slice_n = '0;
                    if (readin_address == LAST_ADDR) begin
                        state_n = DRAIN;
                        ren_n   = 1'b0;
                        drain_n = DRAIN_LOAD;
                    end else begin
                        state_n = P_ADDR;
                        addr_n  = readin_address + 11'd1;
                    end
                end else begin
                    slice_n = slice_state + 2'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_n = READOUT;
                    sb_n    = 1'b0;
                    sum_n   = '0;
                end else begin
                    drain_n = drain_cnt - 1'b1;
                end
            end
            READOUT: begin
                if (rd_ready) begin
                    sum_n = sumout_address + 10'd1;
                    if (sumout_address == LAST_SUM) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                addr_n  = '0;
                ren_n   = 1'b0;
                sb_n    = 1'b0;
                slice_n = '0;
                sum_n   = '0;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_beamformer_sequencer.sv
// Self-checking bench: builds an expected per-cycle trace of each frame from
// the phase rules (capture, 4-cycle words, drain, readout) and replays it.
module tb_beamformer_sequencer;

    localparam int NS = 4;
    localparam int OL = 4;
    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        rst, start, filt_valid, rd_ready;
    logic [10:0] readin_address;
    logic        output_read_en, startbeamformer;
    logic [1:0]  slice_state;
    logic [15:0] sample_index;
    logic [9:0]  sumout_address;
    logic        sumouten, out_valid, busy, done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          fv, rr, st;
        logic [10:0] addr;
        bit          ren, sb;
        logic [1:0]  sl;
        logic [15:0] sidx;
        logic [9:0]  sa;
        bit          soe, ov, bsy, dn;
    } cyc_t;

    cyc_t tr[$];
    int   bp_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    beamformer_sequencer #(
        .NUM_SAMPLES (NS),
        .OUT_LEN     (OL),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .filt_valid     (filt_valid),
        .rd_ready       (rd_ready),
        .readin_address (readin_address),
        .output_read_en (output_read_en),
        .startbeamformer(startbeamformer),
        .slice_state    (slice_state),
        .sample_index   (sample_index),
        .sumout_address (sumout_address),
        .sumouten       (sumouten),
        .out_valid      (out_valid),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare(input int i, input cyc_t e);
        check($sformatf("readin_address@%0d", i),  32'(readin_address),  32'(e.addr));
        check($sformatf("output_read_en@%0d", i),  32'(output_read_en),  32'(e.ren));
        check($sformatf("startbeamformer@%0d", i), 32'(startbeamformer), 32'(e.sb));
        check($sformatf("slice_state@%0d", i),     32'(slice_state),     32'(e.sl));
        check($sformatf("sample_index@%0d", i),    32'(sample_index),    32'(e.sidx));
        check($sformatf("sumout_address@%0d", i),  32'(sumout_address),  32'(e.sa));
        check($sformatf("sumouten@%0d", i),        32'(sumouten),        32'(e.soe));
        check($sformatf("out_valid@%0d", i),       32'(out_valid),       32'(e.ov));
        check($sformatf("busy@%0d", i),            32'(busy),            32'(e.bsy));
        check($sformatf("done@%0d", i),            32'(done),            32'(e.dn));
    endtask

    function automatic cyc_t idle_entry();
        cyc_t c = '{default: 0};
        c.fv = 1'($urandom_range(0, 1));
        c.rr = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // mode: 0 nominal, 1 gapped capture, 2 random with stray starts, 3 backpressure
    function automatic cyc_t busy_entry(input int mode);
        cyc_t c = idle_entry();
        c.bsy = 1'b1;
        if (mode >= 2) c.st = 1'($urandom_range(0, 1));
        return c;
    endfunction

    task automatic build_frame(input int mode);
        cyc_t c;
        int   got, k, j;
        bit   prev;

        c = idle_entry();
        c.st = 1'b1;
        tr.push_back(c);

        got = 0;
        j   = 0;
        while (got < NS) begin
            c = busy_entry(mode);
            c.addr = 11'(got);
            c.sidx = 16'(got);
            case (mode)
                1:       c.fv = (j % 3 == 2);
                2:       c.fv = (j >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
                default: c.fv = 1'b1;
            endcase
            if (c.fv) got++;
            tr.push_back(c);
            j++;
        end

        for (int w = 0; w < NS; w++) begin
            for (int s = 0; s < 4; s++) begin
                c = busy_entry(mode);
                c.addr = 11'(w);
                c.sidx = 16'(w);
                c.ren  = 1'b1;
                c.sb   = 1'b1;
                c.sl   = 2'(s);
                tr.push_back(c);
            end
        end

        for (int d = 0; d < DC; d++) begin
            c = busy_entry(mode);
            c.addr = 11'(NS - 1);
            c.sidx = 16'(NS - 1);
            c.sb   = 1'b1;
            tr.push_back(c);
        end

        k    = 0;
        j    = 0;
        prev = 1'b0;
        while (k < OL) begin
            c = busy_entry(mode);
            c.addr = 11'(NS - 1);
            c.sidx = 16'(NS - 1);
            c.sa   = 10'(k);
            case (mode)
                2:       c.rr = (j >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
                3:       c.rr = bp_pat[j % 7] != 0;
                default: c.rr = 1'b1;
            endcase
            c.soe = c.rr;
            c.ov  = prev;
            prev  = c.soe;
            if (c.rr) k++;
            tr.push_back(c);
            j++;
        end

        c = busy_entry(mode);
        c.addr = 11'(NS - 1);
        c.sidx = 16'(NS - 1);
        c.sa   = 10'(OL);
        c.ov   = 1'b1;
        c.dn   = 1'b1;
        tr.push_back(c);

        repeat (2) tr.push_back(idle_entry());
    endtask

    task automatic replay(input bit abort_mid);
        cyc_t z = '{default: 0};
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            start      = tr[i].st;
            filt_valid = tr[i].fv;
            rd_ready   = tr[i].rr;
            #1;
            compare(i, tr[i]);
            if (abort_mid && tr[i].ren && tr[i].sl == 2'd2 && tr[i].sidx == 16'd2) begin
                rst = 1'b0;
                #1;
                compare(-2, z);
                break;
            end
        end
        tr.delete();
    endtask

    initial begin
        cyc_t z = '{default: 0};

        rst        = 1'b0;
        start      = 1'b1;
        filt_valid = 1'b1;
        rd_ready   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        compare(-1, z);

        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            compare(-1, z);
        end

        build_frame(0); replay(1'b0);
        build_frame(1); replay(1'b0);
        build_frame(3); replay(1'b0);
        build_frame(2); replay(1'b0);

        build_frame(0); replay(1'b1);
        @(negedge clk);
        start      = 1'b0;
        filt_valid = 1'b0;
        rd_ready   = 1'b0;
        rst        = 1'b1;
        #1;
        compare(-3, z);
        build_frame(0); replay(1'b0);

        for (int f = 0; f < 3; f++) begin
            build_frame(2);
            replay(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
